// File: rtl/usensor_emulator_if.sv
// usensor_emulator_if: trigger/echo bundle between a
// ranging driver (master) and the emulated sensor (slave).
interface usensor_emulator_if;
  logic       trig;
  logic [7:0] distance;
  logic       echo;
  logic       busy;
  logic       ignored_trig;
  logic [7:0] meas_count;

  modport master (
    output trig,
    output distance,
    input  echo,
    input  busy,
    input  ignored_trig,
    input  meas_count
  );

  modport slave (
    input  trig,
    input  distance,
    output echo,
    output busy,
    output ignored_trig,
    output meas_count
  );
endinterface

// File: rtl/usensor_emulator.sv
// usensor_emulator: HC-SR04 responder; answers a trigger
// pulse with an echo whose width encodes the distance.
module usensor_emulator #(
  parameter int unsigned TRIG_MIN_CYCLES = 500,
  parameter int unsigned BURST_CYCLES    = 10000,
  parameter int unsigned CYCLES_PER_CM   = 2900,
  parameter int unsigned TIMEOUT_CYCLES  = 1900000,
  parameter int unsigned HOLDOFF_CYCLES  = 50000
) (
  input logic               clock,
  input logic               resetn,
  usensor_emulator_if.slave bus
);

  localparam logic [21:0] T_MIN   = 22'(TRIG_MIN_CYCLES);
  localparam logic [21:0] T_BURST = 22'(BURST_CYCLES);
  localparam logic [21:0] T_CPC   = 22'(CYCLES_PER_CM);
  localparam logic [21:0] T_TMO   = 22'(TIMEOUT_CYCLES);
  localparam logic [21:0] T_HOLD  = 22'(HOLDOFF_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HI,
    BURST,
    ECHO,
    HOLDOFF
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [21:0] cnt;
  logic [21:0] cnt_n;
  logic [21:0] width;
  logic [7:0]  dist_q;
  logic [7:0]  dist_n;
  logic [7:0]  meas_n;
  logic        sync1;
  logic        trig_s;
  logic        trig_d;
  logic        rise;
  logic        cnt_zero;
  logic        wide_ok;
  logic        echo_n;
  logic        busy_n;
  logic        ign_n;

  assign rise     = trig_s & ~trig_d;
  assign cnt_zero = (cnt == '0);
  assign wide_ok  = (cnt >= T_MIN);
  assign width    = {14'd0, dist_q} * T_CPC;

  // Two-flop synchronizer plus one sample of history for edges.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1  <= 1'b0;
      trig_s <= 1'b0;
      trig_d <= 1'b0;
    end else begin
      sync1  <= bus.trig;
      trig_s <= sync1;
      trig_d <= trig_s;
    end
  end

  // State, counter, latched distance and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state            <= IDLE;
      cnt              <= '0;
      dist_q           <= '0;
      bus.echo         <= 1'b0;
      bus.busy         <= 1'b0;
      bus.ignored_trig <= 1'b0;
      bus.meas_count   <= '0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      dist_q           <= dist_n;
      bus.echo         <= echo_n;
      bus.busy         <= busy_n;
      bus.ignored_trig <= ign_n;
      bus.meas_count   <= meas_n;
    end
  end

  // Next state and the shared down/up counter.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n = TRIG_HI;
          cnt_n   = 22'd1;
        end
      end
      TRIG_HI: begin
        if (trig_s) begin
          if (cnt < T_MIN) cnt_n = cnt + 22'd1;
        end else if (wide_ok) begin
          state_n = BURST;
          cnt_n   = T_BURST - 22'd1;
        end else begin
          state_n = IDLE;
        end
      end
      BURST: begin
        if (cnt_zero) begin
          state_n = ECHO;
          cnt_n   = (dist_q == '0) ? T_TMO - 22'd1
                                   : width - 22'd1;
        end else begin
          cnt_n = cnt - 22'd1;
        end
      end
      ECHO: begin
        if (cnt_zero) begin
          state_n = HOLDOFF;
          cnt_n   = T_HOLD - 22'd1;
        end else begin
          cnt_n = cnt - 22'd1;
        end
      end
      HOLDOFF: begin
        if (cnt_zero) state_n = IDLE;
        else          cnt_n   = cnt - 22'd1;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Next values of the registered outputs and the distance latch.
  always_comb begin
    echo_n = bus.echo;
    busy_n = (state_n != IDLE);
    ign_n  = 1'b0;
    meas_n = bus.meas_count;
    dist_n = dist_q;
    unique case (state)
      TRIG_HI: begin
        if (!trig_s && wide_ok) begin
          dist_n = bus.distance;
          meas_n = bus.meas_count + 8'd1;
        end else if (!trig_s) begin
          ign_n = 1'b1;
        end
      end
      BURST: begin
        if (cnt_zero) echo_n = 1'b1;
      end
      ECHO: begin
        if (cnt_zero) echo_n = 1'b0;
      end
      default: begin
        echo_n = bus.echo;
      end
    endcase
  end

endmodule
